// File: rtl/liang_pkg.sv
// Shared types for the load/store unit: access sizes and the bus FSM states.
package liang_pkg;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2,
      SIZE_D = 2'd3
   } lsu_size_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AR   = 3'd1,
      ST_R    = 3'd2,
      ST_WR   = 3'd3,
      ST_B    = 3'd4,
      ST_RESP = 3'd5
   } lsu_state_e;

   // Number of bytes touched by an access of the given size.
   function automatic int size_bytes(input lsu_size_e s);
      return 32'sd1 << s;
   endfunction

endpackage

// File: rtl/lsu_axi_if.sv
// AXI-lite bus between the LSU (master) and the memory arbiter (slave).
interface lsu_axi_if #(
   parameter int XLEN       = 32,
   parameter int ADDR_WIDTH = 32
);
   localparam int STRB_WIDTH = XLEN / 8;

   logic [ADDR_WIDTH-1:0] araddr_o;
   logic                  arvalid_o;
   logic                  arready_i;
   logic [XLEN-1:0]       rdata_i;
   logic [1:0]            rresp_i;
   logic                  rvalid_i;
   logic                  rready_o;
   logic [ADDR_WIDTH-1:0] awaddr_o;
   logic                  awvalid_o;
   logic                  awready_i;
   logic [XLEN-1:0]       wdata_o;
   logic [STRB_WIDTH-1:0] wstrb_o;
   logic                  wvalid_o;
   logic                  wready_i;
   logic [1:0]            bresp_i;
   logic                  bvalid_i;
   logic                  bready_o;

   modport master (
      output araddr_o, arvalid_o, rready_o,
      output awaddr_o, awvalid_o, wdata_o, wstrb_o, wvalid_o, bready_o,
      input  arready_i, rdata_i, rresp_i, rvalid_i,
      input  awready_i, wready_i, bresp_i, bvalid_i
   );

   modport slave (
      input  araddr_o, arvalid_o, rready_o,
      input  awaddr_o, awvalid_o, wdata_o, wstrb_o, wvalid_o, bready_o,
      output arready_i, rdata_i, rresp_i, rvalid_i,
      output awready_i, wready_i, bresp_i, bvalid_i
   );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store data/strobe placement and load lane select plus extension.
module lsu_align
   import liang_pkg::*;
#(
   parameter  int XLEN       = 32,
   localparam int STRB_WIDTH = XLEN / 8,
   localparam int OFF_W      = $clog2(STRB_WIDTH)
) (
   input  lsu_size_e              i_st_size,
   input  logic [OFF_W-1:0]       i_st_off,
   input  logic [XLEN-1:0]        i_st_data,
   output logic [XLEN-1:0]        o_st_data,
   output logic [STRB_WIDTH-1:0]  o_st_strb,
   input  lsu_size_e              i_ld_size,
   input  logic                   i_ld_unsigned,
   input  logic [OFF_W-1:0]       i_ld_off,
   input  logic [XLEN-1:0]        i_ld_data,
   output logic [XLEN-1:0]        o_ld_data
);

   // Extend the low (XLEN-pad) bits of val to the full width; shifting the field to
   // the top and back lets the arithmetic shift do the sign fill.
   function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] val, input int pad,
                                              input logic zext);
      logic        [XLEN-1:0] up;
      logic signed [XLEN-1:0] up_s;
      up   = val << pad;
      up_s = signed'(up);
      if (zext) return up >> pad;
      return unsigned'(up_s >>> pad);
   endfunction

   int               w_nbytes;
   logic [XLEN-1:0]  w_mask;
   logic [15:0]      w_strb_wide;
   logic [XLEN-1:0]  w_ld_shift;
   int               w_pad;

   // Store side: keep only the accessed bytes, then move them to the addressed lane.
   always_comb begin
      w_nbytes = size_bytes(i_st_size);
      w_mask   = '0;
      for (int i = 0; i < XLEN; i++) begin
         if (i < 8 * w_nbytes) w_mask[i] = 1'b1;
      end
      o_st_data   = (i_st_data & w_mask) << {i_st_off, 3'b000};
      w_strb_wide = 16'(((32'd1 << w_nbytes) - 32'd1) << i_st_off);
      o_st_strb   = w_strb_wide[STRB_WIDTH-1:0];
   end

   // Load side: bring the addressed lane down to bit 0 and extend from the access width.
   always_comb begin
      w_ld_shift = i_ld_data >> {i_ld_off, 3'b000};
      case (i_ld_size)
         SIZE_B:  w_pad = XLEN - 8;
         SIZE_H:  w_pad = XLEN - 16;
         SIZE_W:  w_pad = XLEN - 32;
         default: w_pad = 0;
      endcase
      o_ld_data = extend(w_ld_shift, w_pad, i_ld_unsigned);
   end

endmodule

// File: rtl/lsu_axi.sv
// Load/store unit: one outstanding AXI-lite transaction, response held in a register.
module lsu_axi
   import liang_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int STRB_WIDTH = XLEN / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_store_i,
   input  logic [1:0]            req_size_i,
   input  logic                  req_unsigned_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [XLEN-1:0]       req_wdata_i,
   output logic                  resp_valid_o,
   input  logic                  resp_ready_i,
   output logic [XLEN-1:0]       resp_rdata_o,
   output logic                  resp_err_o,
   output logic                  resp_misaligned_o,
   lsu_axi_if.master             axi
);

   localparam int OFF_W = $clog2(STRB_WIDTH);

   lsu_state_e             r_state, w_next;
   lsu_size_e              r_size;
   logic                   r_unsigned;
   logic [OFF_W-1:0]       r_off;
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic [XLEN-1:0]        r_wdata;
   logic [STRB_WIDTH-1:0]  r_wstrb;
   logic                   r_aw_done, r_w_done;
   logic [XLEN-1:0]        r_rdata;
   logic                   r_err, r_mis;

   lsu_size_e              w_req_size;
   logic [XLEN-1:0]        w_st_data, w_ld_data;
   logic [STRB_WIDTH-1:0]  w_st_strb;
   logic [2:0]             w_lowmask;
   logic                   w_misaligned, w_illegal;
   logic                   w_aw_fire, w_w_fire;

   assign w_req_size   = lsu_size_e'(req_size_i);
   assign w_lowmask    = 3'((4'd1 << req_size_i) - 4'd1);
   assign w_misaligned = (req_addr_i[2:0] & w_lowmask) != 3'b000;
   assign w_illegal    = (req_size_i == 2'd3) && (XLEN == 32);
   assign w_aw_fire    = axi.awvalid_o & axi.awready_i;
   assign w_w_fire     = axi.wvalid_o & axi.wready_i;

   lsu_align #(.XLEN(XLEN)) u_align (
      .i_st_size     (w_req_size),
      .i_st_off      (req_addr_i[OFF_W-1:0]),
      .i_st_data     (req_wdata_i),
      .o_st_data     (w_st_data),
      .o_st_strb     (w_st_strb),
      .i_ld_size     (r_size),
      .i_ld_unsigned (r_unsigned),
      .i_ld_off      (r_off),
      .i_ld_data     (axi.rdata_i),
      .o_ld_data     (w_ld_data)
   );

   // State register; reset abandons any bus handshake in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // Next state and handshake outputs, all decoded from registered state only.
   always_comb begin
      w_next        = r_state;
      req_ready_o   = 1'b0;
      resp_valid_o  = 1'b0;
      axi.arvalid_o = 1'b0;
      axi.rready_o  = 1'b0;
      axi.awvalid_o = 1'b0;
      axi.wvalid_o  = 1'b0;
      axi.bready_o  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               if (w_misaligned || w_illegal) w_next = ST_RESP;
               else if (req_store_i)          w_next = ST_WR;
               else                           w_next = ST_AR;
            end
         end
         ST_AR: begin
            axi.arvalid_o = 1'b1;
            if (axi.arready_i) w_next = ST_R;
         end
         ST_R: begin
            axi.rready_o = 1'b1;
            if (axi.rvalid_i) w_next = ST_RESP;
         end
         ST_WR: begin
            axi.awvalid_o = ~r_aw_done;
            axi.wvalid_o  = ~r_w_done;
            if ((r_aw_done || axi.awready_i) && (r_w_done || axi.wready_i)) w_next = ST_B;
         end
         ST_B: begin
            axi.bready_o = 1'b1;
            if (axi.bvalid_i) w_next = ST_RESP;
         end
         ST_RESP: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Request capture, AW/W completion flags and the held response.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_size     <= SIZE_B;
         r_unsigned <= 1'b0;
         r_off      <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_aw_done  <= 1'b0;
         r_w_done   <= 1'b0;
         r_rdata    <= '0;
         r_err      <= 1'b0;
         r_mis      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid_i) begin
                  r_size     <= w_req_size;
                  r_unsigned <= req_unsigned_i;
                  r_off      <= req_addr_i[OFF_W-1:0];
                  r_addr     <= {req_addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                  if (req_store_i) begin
                     r_wdata <= w_st_data;
                     r_wstrb <= w_st_strb;
                  end
                  r_aw_done  <= 1'b0;
                  r_w_done   <= 1'b0;
                  r_rdata    <= '0;
                  r_err      <= w_illegal;
                  r_mis      <= w_misaligned;
               end
            end
            ST_R: begin
               if (axi.rvalid_i) begin
                  r_err   <= axi.rresp_i != 2'b00;
                  r_rdata <= (axi.rresp_i != 2'b00) ? '0 : w_ld_data;
               end
            end
            ST_WR: begin
               if (w_aw_fire) r_aw_done <= 1'b1;
               if (w_w_fire)  r_w_done  <= 1'b1;
            end
            ST_B: begin
               if (axi.bvalid_i) r_err <= axi.bresp_i != 2'b00;
            end
            default: ;
         endcase
      end
   end

   assign axi.araddr_o      = r_addr;
   assign axi.awaddr_o      = r_addr;
   assign axi.wdata_o       = r_wdata;
   assign axi.wstrb_o       = r_wstrb;
   assign resp_rdata_o      = r_rdata;
   assign resp_err_o        = r_err;
   assign resp_misaligned_o = r_mis;

endmodule

// File: tb/tb_lsu_axi.sv
// Bench for lsu_axi: one 32-bit and one 64-bit instance, each with its own bus.
module tb_lsu_axi;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Shared request fields, per-instance valid/ready
   logic        q_valid32, q_valid64, q_store, q_uns, resp_ready32, resp_ready64;
   logic [1:0]  q_size;
   logic [31:0] q_addr;
   logic [63:0] q_wdata;

   logic        ready32, rv32, err32, mis32;
   logic [31:0] rd32;
   logic        ready64, rv64, err64, mis64;
   logic [63:0] rd64;

   lsu_axi_if #(.XLEN(32), .ADDR_WIDTH(32)) bus32 ();
   lsu_axi_if #(.XLEN(64), .ADDR_WIDTH(32)) bus64 ();

   lsu_axi #(.XLEN(32), .ADDR_WIDTH(32)) dut32 (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(q_valid32), .req_ready_o(ready32), .req_store_i(q_store),
      .req_size_i(q_size), .req_unsigned_i(q_uns), .req_addr_i(q_addr),
      .req_wdata_i(q_wdata[31:0]),
      .resp_valid_o(rv32), .resp_ready_i(resp_ready32), .resp_rdata_o(rd32),
      .resp_err_o(err32), .resp_misaligned_o(mis32),
      .axi(bus32)
   );

   lsu_axi #(.XLEN(64), .ADDR_WIDTH(32)) dut64 (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(q_valid64), .req_ready_o(ready64), .req_store_i(q_store),
      .req_size_i(q_size), .req_unsigned_i(q_uns), .req_addr_i(q_addr),
      .req_wdata_i(q_wdata),
      .resp_valid_o(rv64), .resp_ready_i(resp_ready64), .resp_rdata_o(rd64),
      .resp_err_o(err64), .resp_misaligned_o(mis64),
      .axi(bus64)
   );

   // Bus activity monitors for the 32-bit instance
   int n_ar32 = 0;
   int n_aw32 = 0;
   int n_w32  = 0;
   always @(posedge clk) begin
      if (bus32.arvalid_o) n_ar32 <= n_ar32 + 1;
      if (bus32.awvalid_o) n_aw32 <= n_aw32 + 1;
      if (bus32.wvalid_o)  n_w32  <= n_w32 + 1;
   end

   // Reference model: arithmetic on whole bus words
   function automatic logic [63:0] ref_load(input logic [63:0] bus, input int xlen, input int size,
                                            input bit uns, input logic [63:0] addr);
      int nb, off;
      logic [63:0] m, v;
      nb  = 1 << size;
      off = int'(addr % 64'(xlen / 8));
      m   = (nb == 8) ? {64{1'b1}} : ((64'd1 << (8 * nb)) - 64'd1);
      v   = (bus >> (8 * off)) & m;
      if (!uns && (((v >> (8 * nb - 1)) & 64'd1) == 64'd1)) v = v | ~m;
      if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
      return v;
   endfunction

   function automatic logic [63:0] ref_store(input logic [63:0] wd, input int xlen, input int size,
                                             input logic [63:0] addr);
      int nb, off;
      logic [63:0] m;
      nb  = 1 << size;
      off = int'(addr % 64'(xlen / 8));
      m   = (nb == 8) ? {64{1'b1}} : ((64'd1 << (8 * nb)) - 64'd1);
      return (wd & m) << (8 * off);
   endfunction

   function automatic logic [7:0] ref_strb(input int xlen, input int size, input logic [63:0] addr);
      int off;
      off = int'(addr % 64'(xlen / 8));
      return 8'(((32'd1 << (1 << size)) - 32'd1) << off);
   endfunction

   function automatic logic [63:0] strb_mask(input logic [7:0] s);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 8; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
      return m;
   endfunction

   task automatic idle_slaves;
      bus32.arready_i = 0; bus32.rvalid_i = 0; bus32.rdata_i = '0; bus32.rresp_i = 0;
      bus32.awready_i = 0; bus32.wready_i = 0; bus32.bvalid_i = 0; bus32.bresp_i = 0;
      bus64.arready_i = 0; bus64.rvalid_i = 0; bus64.rdata_i = '0; bus64.rresp_i = 0;
      bus64.awready_i = 0; bus64.wready_i = 0; bus64.bvalid_i = 0; bus64.bresp_i = 0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      q_valid32 = 0; q_valid64 = 0; q_store = 0; q_uns = 0; q_size = 0; q_addr = '0; q_wdata = '0;
      resp_ready32 = 0; resp_ready64 = 0;
      idle_slaves();
      repeat (2) @(negedge clk);
      n_tests++;
      if ({ready32, rv32, bus32.arvalid_o, bus32.rready_o, bus32.awvalid_o, bus32.wvalid_o,
           bus32.bready_o} !== 7'b1000000) begin
         n_fail++;
         $display("FAIL reset_ctl32 got rdy=%0b rv=%0b ar=%0b r=%0b aw=%0b w=%0b b=%0b want 1000000",
                  ready32, rv32, bus32.arvalid_o, bus32.rready_o, bus32.awvalid_o, bus32.wvalid_o,
                  bus32.bready_o);
      end
      n_tests++;
      if ({bus32.araddr_o, bus32.awaddr_o, bus32.wdata_o, bus32.wstrb_o, rd32, err32, mis32} !== '0) begin
         n_fail++;
         $display("FAIL reset_data32 got ar=%h aw=%h wd=%h ws=%h rd=%h e=%0b m=%0b want all 0",
                  bus32.araddr_o, bus32.awaddr_o, bus32.wdata_o, bus32.wstrb_o, rd32, err32, mis32);
      end
      n_tests++;
      if ({ready64, rv64, bus64.arvalid_o, bus64.awvalid_o, bus64.wvalid_o, rd64, bus64.wstrb_o}
          !== {1'b1, 4'b0, 64'd0, 8'd0}) begin
         n_fail++;
         $display("FAIL reset_64 got rdy=%0b rv=%0b ar=%0b aw=%0b w=%0b rd=%h ws=%h want rdy=1 rest 0",
                  ready64, rv64, bus64.arvalid_o, bus64.awvalid_o, bus64.wvalid_o, rd64, bus64.wstrb_o);
      end
      rst = 1'b0;
   endtask

   task automatic test_lb;
      logic [31:0] want;
      for (int u = 0; u < 2; u++) begin
         want = (u == 1) ? 32'h0000_0080 : 32'hFFFF_FF80;
         @(negedge clk);
         q_valid32 = 1; q_store = 0; q_size = 2'd0; q_uns = 1'(u); q_addr = 32'h1003;
         bus32.arready_i = 1; bus32.rvalid_i = 1; bus32.rdata_i = 32'h8011_2233; bus32.rresp_i = 0;
         @(negedge clk);
         q_valid32 = 0;
         n_tests++;
         if ({bus32.arvalid_o, bus32.araddr_o} !== {1'b1, 32'h1000}) begin
            n_fail++;
            $display("FAIL lb_ar u=%0d got v=%0b a=%h want v=1 a=00001000", u, bus32.arvalid_o, bus32.araddr_o);
         end
         @(negedge clk);
         @(negedge clk);
         n_tests++;
         if ({rv32, err32, mis32, rd32} !== {3'b100, want}) begin
            n_fail++;
            $display("FAIL lb_resp u=%0d got v=%0b e=%0b m=%0b d=%h want v=1 d=%h", u, rv32, err32, mis32, rd32, want);
         end
         resp_ready32 = 1;
         @(negedge clk);
         resp_ready32 = 0;
         idle_slaves();
      end
   endtask

   task automatic test_sh;
      @(negedge clk);
      q_valid32 = 1; q_store = 1; q_size = 2'd1; q_uns = 0; q_addr = 32'h2002; q_wdata = 64'hABCD;
      bus32.awready_i = 1; bus32.wready_i = 1; bus32.bvalid_i = 1; bus32.bresp_i = 0;
      @(negedge clk);
      q_valid32 = 0;
      n_tests++;
      if ({bus32.awvalid_o, bus32.wvalid_o, bus32.awaddr_o, bus32.wdata_o, bus32.wstrb_o}
          !== {2'b11, 32'h2000, 32'hABCD_0000, 4'b1100}) begin
         n_fail++;
         $display("FAIL sh_bus got aw=%0b w=%0b a=%h d=%h s=%b want 1 1 00002000 abcd0000 1100",
                  bus32.awvalid_o, bus32.wvalid_o, bus32.awaddr_o, bus32.wdata_o, bus32.wstrb_o);
      end
      @(negedge clk);
      n_tests++;
      if ({bus32.bready_o, bus32.awvalid_o, bus32.wvalid_o} !== 3'b100) begin
         n_fail++;
         $display("FAIL sh_b got b=%0b aw=%0b w=%0b want 100", bus32.bready_o, bus32.awvalid_o, bus32.wvalid_o);
      end
      @(negedge clk);
      n_tests++;
      if ({rv32, err32, mis32, rd32} !== {3'b100, 32'd0}) begin
         n_fail++;
         $display("FAIL sh_resp got v=%0b e=%0b m=%0b d=%h want 1 0 0 0", rv32, err32, mis32, rd32);
      end
      resp_ready32 = 1;
      @(negedge clk);
      resp_ready32 = 0;
      idle_slaves();
   endtask

   task automatic test_sw_stall;
      int resp_seen;
      logic [6:0] aw_seq, w_seq;
      resp_seen = 0; aw_seq = '0; w_seq = '0;
      @(negedge clk);
      q_valid32 = 1; q_store = 1; q_size = 2'd2; q_addr = 32'h3000; q_wdata = 64'hDEAD_BEEF;
      bus32.awready_i = 1; bus32.wready_i = 0; bus32.bvalid_i = 0;
      for (int t = 1; t <= 7; t++) begin
         @(negedge clk);
         q_valid32 = 0;
         aw_seq[t-1] = bus32.awvalid_o;
         w_seq[t-1]  = bus32.wvalid_o;
         if (rv32) resp_seen++;
         if (t == 2) bus32.awready_i = 0;
         if (t == 4) bus32.wready_i = 1;
         if (t == 5) begin
            n_tests++;
            if ({bus32.bready_o, bus32.wvalid_o} !== 2'b10) begin
               n_fail++;
               $display("FAIL sw_stall_b got bready=%0b wvalid=%0b want 1 0", bus32.bready_o, bus32.wvalid_o);
            end
            bus32.wready_i = 0; bus32.bvalid_i = 1;
         end
         if (t == 6) begin
            n_tests++;
            if ({rv32, err32} !== 2'b10) begin
               n_fail++;
               $display("FAIL sw_stall_resp got v=%0b e=%0b want 1 0", rv32, err32);
            end
            resp_ready32 = 1;
         end
         if (t == 7) resp_ready32 = 0;
      end
      n_tests++;
      if ({aw_seq, w_seq} !== {7'b0000001, 7'b0001111}) begin
         n_fail++;
         $display("FAIL sw_stall_valids got aw=%b w=%b want aw=0000001 w=0001111", aw_seq, w_seq);
      end
      n_tests++;
      if (resp_seen !== 1) begin
         n_fail++;
         $display("FAIL sw_stall_nresp got %0d want 1", resp_seen);
      end
      idle_slaves();
   endtask

   task automatic test_no_bus(input logic st, input logic [1:0] sz, input logic [31:0] a,
                              input logic want_err, input logic want_mis);
      int ar0, aw0;
      ar0 = n_ar32; aw0 = n_aw32;
      @(negedge clk);
      q_valid32 = 1; q_store = st; q_size = sz; q_addr = a; q_wdata = 64'h1234_5678;
      @(negedge clk);
      q_valid32 = 0;
      n_tests++;
      if ({rv32, err32, mis32, rd32} !== {1'b1, want_err, want_mis, 32'd0}) begin
         n_fail++;
         $display("FAIL no_bus_resp sz=%0d a=%h got v=%0b e=%0b m=%0b d=%h want v=1 e=%0b m=%0b d=0",
                  sz, a, rv32, err32, mis32, rd32, want_err, want_mis);
      end
      resp_ready32 = 1;
      @(negedge clk);
      resp_ready32 = 0;
      @(negedge clk);
      n_tests++;
      if ({n_ar32 - ar0, n_aw32 - aw0, ready32} !== {32'd0, 32'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL no_bus_traffic sz=%0d got ar=%0d aw=%0d rdy=%0b want 0 0 1",
                  sz, n_ar32 - ar0, n_aw32 - aw0, ready32);
      end
   endtask

   task automatic test_misaligned;
      test_no_bus(1'b0, 2'd2, 32'h1002, 1'b0, 1'b1);
      test_no_bus(1'b1, 2'd1, 32'h1001, 1'b0, 1'b1);
   endtask

   task automatic test_illegal_size;
      test_no_bus(1'b0, 2'd3, 32'h0010, 1'b1, 1'b0);
      test_no_bus(1'b1, 2'd3, 32'h0018, 1'b1, 1'b0);
   endtask

   task automatic test_random_load;
      logic [31:0] a, d, want;
      logic [1:0]  rr;
      int sz;
      bit u, e;
      for (int k = 0; k < 20; k++) begin
         sz = $urandom_range(0, 2);
         u  = 1'($urandom_range(0, 1));
         e  = ($urandom_range(0, 5) == 0);
         a  = $urandom & ~((32'd1 << sz) - 32'd1);
         d  = $urandom;
         rr = e ? 2'($urandom_range(1, 3)) : 2'b00;
         want = e ? 32'd0 : 32'(ref_load({32'd0, d}, 32, sz, u, {32'd0, a}));
         @(negedge clk);
         n_tests++;
         if (ready32 !== 1'b1) begin
            n_fail++;
            $display("FAIL rld_ready k=%0d got %0b want 1", k, ready32);
         end
         q_valid32 = 1; q_store = 0; q_size = 2'(sz); q_uns = u; q_addr = a;
         bus32.arready_i = 1; bus32.rvalid_i = 1; bus32.rdata_i = d; bus32.rresp_i = rr;
         @(negedge clk);
         q_valid32 = 0;
         n_tests++;
         if ({bus32.arvalid_o, bus32.araddr_o} !== {1'b1, a & 32'hFFFF_FFFC}) begin
            n_fail++;
            $display("FAIL rld_ar k=%0d got v=%0b a=%h want v=1 a=%h", k, bus32.arvalid_o, bus32.araddr_o,
                     a & 32'hFFFF_FFFC);
         end
         @(negedge clk);
         n_tests++;
         if ({bus32.rready_o, bus32.arvalid_o, rv32} !== 3'b100) begin
            n_fail++;
            $display("FAIL rld_r k=%0d got rready=%0b ar=%0b rv=%0b want 1 0 0", k, bus32.rready_o,
                     bus32.arvalid_o, rv32);
         end
         @(negedge clk);
         n_tests++;
         if ({rv32, err32, mis32, rd32} !== {1'b1, e, 1'b0, want}) begin
            n_fail++;
            $display("FAIL rld_resp k=%0d sz=%0d u=%0b a=%h bus=%h got v=%0b e=%0b m=%0b d=%h want e=%0b d=%h",
                     k, sz, u, a, d, rv32, err32, mis32, rd32, e, want);
         end
         resp_ready32 = 1;
         @(negedge clk);
         resp_ready32 = 0;
         idle_slaves();
         n_tests++;
         if ({rv32, ready32} !== 2'b01) begin
            n_fail++;
            $display("FAIL rld_after k=%0d got rv=%0b rdy=%0b want 0 1", k, rv32, ready32);
         end
      end
   endtask

   task automatic test_random_store;
      logic [31:0] a, wd, want_d, m;
      logic [3:0]  want_s;
      logic [1:0]  br;
      int sz;
      bit e;
      for (int k = 0; k < 20; k++) begin
         sz = $urandom_range(0, 2);
         e  = ($urandom_range(0, 5) == 0);
         a  = $urandom & ~((32'd1 << sz) - 32'd1);
         wd = $urandom;
         br = e ? 2'($urandom_range(1, 3)) : 2'b00;
         want_d = 32'(ref_store({32'd0, wd}, 32, sz, {32'd0, a}));
         want_s = 4'(ref_strb(32, sz, {32'd0, a}));
         m      = 32'(strb_mask({4'd0, want_s}));
         @(negedge clk);
         q_valid32 = 1; q_store = 1; q_size = 2'(sz); q_uns = 0; q_addr = a; q_wdata = {32'd0, wd};
         bus32.awready_i = 1; bus32.wready_i = 1; bus32.bvalid_i = 1; bus32.bresp_i = br;
         @(negedge clk);
         q_valid32 = 0;
         n_tests++;
         if ({bus32.awvalid_o, bus32.wvalid_o, bus32.awaddr_o, bus32.wstrb_o, bus32.wdata_o & m}
             !== {2'b11, a & 32'hFFFF_FFFC, want_s, want_d}) begin
            n_fail++;
            $display("FAIL rst_bus k=%0d sz=%0d a=%h wd=%h got aw=%0b w=%0b addr=%h s=%b d=%h want addr=%h s=%b d=%h",
                     k, sz, a, wd, bus32.awvalid_o, bus32.wvalid_o, bus32.awaddr_o, bus32.wstrb_o,
                     bus32.wdata_o & m, a & 32'hFFFF_FFFC, want_s, want_d);
         end
         @(negedge clk);
         n_tests++;
         if ({bus32.bready_o, bus32.awvalid_o, bus32.wvalid_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL rst_b k=%0d got b=%0b aw=%0b w=%0b want 1 0 0", k, bus32.bready_o,
                     bus32.awvalid_o, bus32.wvalid_o);
         end
         @(negedge clk);
         n_tests++;
         if ({rv32, err32, mis32, rd32} !== {1'b1, e, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL rst_resp k=%0d got v=%0b e=%0b m=%0b d=%h want v=1 e=%0b d=0", k, rv32, err32,
                     mis32, rd32, e);
         end
         resp_ready32 = 1;
         @(negedge clk);
         resp_ready32 = 0;
         idle_slaves();
      end
   endtask

   task automatic test_ld64;
      logic [63:0] d, want;
      logic [31:0] a;
      logic [1:0]  rr;
      int sz;
      bit u, e;
      for (int k = 0; k < 13; k++) begin
         if (k == 0) begin
            sz = 3; u = 0; e = 1; a = 32'h8; rr = 2'b10; d = 64'hFEDC_BA98_7654_3210;
         end else begin
            sz = $urandom_range(0, 3);
            u  = 1'($urandom_range(0, 1));
            e  = 0; rr = 2'b00;
            a  = $urandom & ~((32'd1 << sz) - 32'd1);
            d  = {$urandom, $urandom};
         end
         want = e ? 64'd0 : ref_load(d, 64, sz, u, {32'd0, a});
         @(negedge clk);
         q_valid64 = 1; q_store = 0; q_size = 2'(sz); q_uns = u; q_addr = a;
         bus64.arready_i = 1; bus64.rvalid_i = 1; bus64.rdata_i = d; bus64.rresp_i = rr;
         @(negedge clk);
         q_valid64 = 0;
         n_tests++;
         if ({bus64.arvalid_o, bus64.araddr_o} !== {1'b1, a & 32'hFFFF_FFF8}) begin
            n_fail++;
            $display("FAIL ld64_ar k=%0d got v=%0b a=%h want v=1 a=%h", k, bus64.arvalid_o, bus64.araddr_o,
                     a & 32'hFFFF_FFF8);
         end
         @(negedge clk);
         @(negedge clk);
         n_tests++;
         if ({rv64, err64, mis64, rd64} !== {1'b1, e, 1'b0, want}) begin
            n_fail++;
            $display("FAIL ld64_resp k=%0d sz=%0d u=%0b a=%h got v=%0b e=%0b m=%0b d=%h want e=%0b d=%h",
                     k, sz, u, a, rv64, err64, mis64, rd64, e, want);
         end
         resp_ready64 = 1;
         @(negedge clk);
         resp_ready64 = 0;
         idle_slaves();
      end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      q_valid32 = 1; q_store = 1; q_size = 2'd2; q_addr = 32'h4000; q_wdata = 64'h5555_AAAA;
      bus32.awready_i = 0; bus32.wready_i = 0;
      @(negedge clk);
      q_valid32 = 0;
      n_tests++;
      if ({bus32.awvalid_o, bus32.wvalid_o} !== 2'b11) begin
         n_fail++;
         $display("FAIL rmid_pre got aw=%0b w=%0b want 1 1", bus32.awvalid_o, bus32.wvalid_o);
      end
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if ({bus32.awvalid_o, bus32.wvalid_o} !== 2'b00) begin
         n_fail++;
         $display("FAIL rmid_drop got aw=%0b w=%0b want 0 0", bus32.awvalid_o, bus32.wvalid_o);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({ready32, rv32, bus32.awvalid_o, bus32.wvalid_o, bus32.bready_o} !== 5'b10000) begin
         n_fail++;
         $display("FAIL rmid_after got rdy=%0b rv=%0b aw=%0b w=%0b b=%0b want 1 0 0 0 0", ready32, rv32,
                  bus32.awvalid_o, bus32.wvalid_o, bus32.bready_o);
      end
   endtask

   initial begin
      test_reset();
      test_lb();
      test_sh();
      test_sw_stall();
      test_misaligned();
      test_illegal_size();
      test_random_load();
      test_random_store();
      test_ld64();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_axi.md
# lsu_axi

Parametrised load/store unit between the EXU and the memory arbiter, replacing the single-width, fixed-protocol LSU. Supports XLEN of 32 or 64 with matching AXI-lite data width, signed/unsigned byte/half/word/dword accesses, and misalignment detection. AW and W acceptance are tracked independently, and RRESP/BRESP errors are propagated. The response is held in a register, so a stalled EXU never holds the AXI R/B channels.

## Interface
Parameters:
- XLEN, 32: data and bus width; legal values are 32 and 64.
- ADDR_WIDTH, 32: address width.
- STRB_WIDTH, XLEN/8: derived; write-strobe width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  EXU request valid
- req_ready_o  out  1  LSU can accept a request
- req_store_i  in  1  0 = load, 1 = store
- req_size_i  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword
- req_unsigned_i  in  1  loads only: zero-extend instead of sign-extend
- req_addr_i  in  ADDR_WIDTH  byte address
- req_wdata_i  in  XLEN  store data, right-justified
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  EXU accepts the response
- resp_rdata_o  out  XLEN  extended load data; 0 for stores and errors
- resp_err_o  out  1  bus error (RRESP/BRESP != 0) or illegal size
- resp_misaligned_o  out  1  address not naturally aligned for req_size_i
- araddr_o  out  ADDR_WIDTH  read address, aligned to STRB_WIDTH
- arvalid_o  out  1  read address valid
- arready_i  in  1  read address ready
- rdata_i  in  XLEN  read data
- rresp_i  in  2  read response
- rvalid_i  in  1  read data valid
- rready_o  out  1  read data ready
- awaddr_o  out  ADDR_WIDTH  write address, aligned to STRB_WIDTH
- awvalid_o  out  1  write address valid
- awready_i  in  1  write address ready
- wdata_o  out  XLEN  lane-shifted write data
- wstrb_o  out  STRB_WIDTH  byte strobes
- wvalid_o  out  1  write data valid
- wready_i  in  1  write data ready
- bresp_i  in  2  write response
- bvalid_i  in  1  write response valid
- bready_o  out  1  write response ready

## Operation
- States: IDLE, AR, R, WR, B, RESP.
- IDLE
  - req_ready_o = 1.
  - On req fire, register store flag, size, unsigned flag, address, shifted wdata and strobes.
  - A size that is misaligned (addr mod 2^size != 0), or size 3 with XLEN = 32, goes straight to RESP with resp_misaligned_o or resp_err_o set. No bus traffic is issued.
  - Otherwise a load goes to AR and a store goes to WR.
- AR: arvalid_o = 1; on arready_i go to R.
- R: rready_o = 1; on rvalid_i capture the extracted, extended data (or the error) and go to RESP.
- WR
  - awvalid_o is high until AW fires; wvalid_o is high until W fires.
  - aw_done and w_done flags record each handshake.
  - Go to B in the cycle the later of the two fires; simultaneous fire is allowed.
- B: bready_o = 1; on bvalid_i record bresp_i != 0 as the error and go to RESP.
- RESP: resp_valid_o = 1; on resp_ready_i go to IDLE.
- Load extraction
  - Select the lane at addr[log2(STRB_WIDTH)-1:0].
  - Sign- or zero-extend from 8, 16 or 32 bits; size 3 passes the full bus.
- Store alignment
  - wdata is replicated or shifted into the addressed lane.
  - wstrb = ((1 << 2^size) - 1) << lane offset.
- On resp_err_o, resp_rdata_o = 0.

## Timing
- Reset values: all valid/ready outputs are 0 except req_ready_o = 1; all data, address and strobe outputs are 0; state is IDLE; aw_done = w_done = 0.
- Reset mid-transaction drops every valid immediately, without completing the AXI handshake.
- AXI outputs are registered-state driven; there are no combinational paths from req_* to AXI outputs.
- Load latency, zero-wait slave: req fire at T, arvalid at T+1, rvalid at T+2, resp_valid at T+3.
- Store latency: AW/W at T+1, B at T+2, resp_valid at T+3.
- Misaligned or illegal request: resp_valid at T+1.
- Once asserted, arvalid_o, awvalid_o and wvalid_o and their payloads stay stable until the handshake.
- resp_valid_o and its payload stay stable until resp_ready_i.
- At most one transaction is outstanding; the next request is accepted no earlier than the cycle after the response fires.

## Structure
- liang_pkg holds lsu_size_e (SIZE_B, SIZE_H, SIZE_W, SIZE_D) and the lsu_state_e enum.
- Sub-module lsu_align (combinational, parameter XLEN) holds store lane-shift/strobe generation and load lane-select/extension.
- lsu_axi holds the FSM, the done flags and the response register.

## Test plan
- XLEN = 32, lb at 0x1003, rdata 0x80112233 → resp_rdata 0xFFFFFF80, resp_valid at T+3; lbu → 0x00000080.
- XLEN = 32, sh 0xABCD to 0x2002 → awaddr 0x2000, wdata 0xABCD0000, wstrb 4'b1100.
- XLEN = 32, sw: awready at T+1, wready held low until T+4 → awvalid drops after T+1, wvalid holds until T+4, bready at T+5, single response.
- lw at 0x1002 → resp_misaligned_o = 1 at T+1; no arvalid ever asserted.
- XLEN = 64, ld at 0x8 with rresp 2'b10 → resp_err_o = 1, resp_rdata_o = 0; XLEN = 32, size 3 → resp_err_o = 1 with no bus traffic.
- Assert rst_i while in WR with awvalid high → awvalid/wvalid 0 in the same cycle; req_ready_o = 1 after reset is released.
